// File: rtl/snn_pkg.sv
// Shared widths, spike codes and arbiter state type for the spiking-network blocks.
package snn_pkg;

    localparam int unsigned NEURON_ID_WIDTH = 9;
    localparam int unsigned TEN_DATA_WIDTH  = 2;
    localparam int unsigned SPIKE_IN_WIDTH  = TEN_DATA_WIDTH + NEURON_ID_WIDTH;

    localparam logic [1:0] SPK_NONE = 2'd0;
    localparam logic [1:0] SPK_POS  = 2'd1;
    localparam logic [1:0] SPK_NEG  = 2'd2;
    localparam logic [1:0] SPK_ILL  = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StScan,
        StRelease,
        StFinish
    } arb_state_e;

endpackage

// File: rtl/spike_network_arbiter.sv
// Network-phase sequencer: waits for all active neurons, picks one firing neuron
// by a one-per-cycle round-robin scan, broadcasts it and counts iterations.
module spike_network_arbiter
    import snn_pkg::*;
#(
    parameter int unsigned NUM_NEURON      = 512,
    parameter int unsigned NEURON_ID_WIDTH = snn_pkg::NEURON_ID_WIDTH,
    parameter int unsigned TEN_DATA_WIDTH  = snn_pkg::TEN_DATA_WIDTH,
    parameter int unsigned ITER_WIDTH      = 16
) (
    input  logic                                 clk,
    input  logic                                 reset_l,
    input  logic                                 start,
    input  logic [NEURON_ID_WIDTH-1:0]           active_neuron,
    input  logic [ITER_WIDTH-1:0]                max_iter,
    input  logic [NUM_NEURON-1:0]                en_network,
    input  logic [TEN_DATA_WIDTH*NUM_NEURON-1:0] spike_out,
    output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_in,
    output logic                                 networkDone,
    output logic [ITER_WIDTH-1:0]                iter_count,
    output logic                                 busy,
    output logic                                 anneal_done,
    output logic                                 illegal_spike
);

    // One extra bit so that n_eff can hold NUM_NEURON itself (e.g. 512 with 9-bit ids).
    localparam int unsigned CNT_W = NEURON_ID_WIDTH + 1;
    localparam int unsigned SPK_W = TEN_DATA_WIDTH + NEURON_ID_WIDTH;

    arb_state_e                  state_q, state_d;
    logic [NEURON_ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NEURON_ID_WIDTH-1:0]  scan_idx_q, scan_idx_d;
    logic [CNT_W-1:0]            scan_cnt_q, scan_cnt_d;
    logic [SPK_W-1:0]            spike_in_q, spike_in_d;
    logic [ITER_WIDTH-1:0]       iter_q, iter_d;
    logic                        illegal_q, illegal_d;

    logic [CNT_W-1:0]            n_eff;
    logic                        ready;
    logic [TEN_DATA_WIDTH-1:0]   cur_code;
    logic [CNT_W-1:0]            idx_plus1;
    logic [NEURON_ID_WIDTH-1:0]  idx_wrap;
    logic                        hit;
    logic                        last_slot;

    // Effective neuron count: active_neuron clamped to the attached bank size.
    always_comb begin
        if ({1'b0, active_neuron} > CNT_W'(NUM_NEURON)) begin
            n_eff = CNT_W'(NUM_NEURON);
        end else begin
            n_eff = {1'b0, active_neuron};
        end
    end

    // Ready when every neuron below n_eff is parked; higher indices are ignored.
    always_comb begin
        ready = 1'b1;
        for (int i = 0; i < NUM_NEURON; i++) begin
            if ((CNT_W'(i) < n_eff) && !en_network[i]) begin
                ready = 1'b0;
            end
        end
    end

    // Spike code of the neuron currently under the scan pointer.
    always_comb begin
        cur_code = '0;
        for (int i = 0; i < NUM_NEURON; i++) begin
            if (scan_idx_q == NEURON_ID_WIDTH'(i)) begin
                cur_code = spike_out[i*TEN_DATA_WIDTH +: TEN_DATA_WIDTH];
            end
        end
    end

    // Scan-pointer increment wrapping at n_eff, plus hit / last-slot decode.
    always_comb begin
        idx_plus1 = {1'b0, scan_idx_q} + CNT_W'(1);
        if (idx_plus1 >= n_eff) begin
            idx_wrap = '0;
        end else begin
            idx_wrap = idx_plus1[NEURON_ID_WIDTH-1:0];
        end
        hit       = (cur_code == TEN_DATA_WIDTH'(SPK_POS)) ||
                    (cur_code == TEN_DATA_WIDTH'(SPK_NEG));
        last_slot = (scan_cnt_q == (n_eff - CNT_W'(1)));
    end

    // Next-state logic for the network-phase sequencer.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        scan_idx_d = scan_idx_q;
        scan_cnt_d = scan_cnt_q;
        spike_in_d = spike_in_q;
        iter_d     = iter_q;
        illegal_d  = illegal_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (max_iter == '0) begin
                        state_d = StFinish;
                    end else begin
                        iter_d  = '0;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (ready) begin
                    if (n_eff == '0) begin
                        spike_in_d = '0;
                        state_d    = StRelease;
                    end else begin
                        scan_idx_d = rr_ptr_q;
                        scan_cnt_d = '0;
                        state_d    = StScan;
                    end
                end
            end
            StScan: begin
                if (cur_code == TEN_DATA_WIDTH'(SPK_ILL)) begin
                    illegal_d = 1'b1;
                end
                if (hit) begin
                    spike_in_d = {cur_code, scan_idx_q};
                    rr_ptr_d   = idx_wrap;
                    state_d    = StRelease;
                end else if (last_slot) begin
                    spike_in_d = '0;
                    state_d    = StRelease;
                end else begin
                    scan_idx_d = idx_wrap;
                    scan_cnt_d = scan_cnt_q + CNT_W'(1);
                end
            end
            StRelease: begin
                iter_d = iter_q + ITER_WIDTH'(1);
                if (iter_d == max_iter) begin
                    state_d = StFinish;
                end else begin
                    state_d = StWait;
                end
            end
            StFinish: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            scan_idx_q <= '0;
            scan_cnt_q <= '0;
            spike_in_q <= '0;
            iter_q     <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            scan_idx_q <= scan_idx_d;
            scan_cnt_q <= scan_cnt_d;
            spike_in_q <= spike_in_d;
            iter_q     <= iter_d;
            illegal_q  <= illegal_d;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        spike_in      = spike_in_q;
        iter_count    = iter_q;
        illegal_spike = illegal_q;
        networkDone   = (state_q == StRelease);
        anneal_done   = (state_q == StFinish);
        busy          = (state_q != StIdle) && (state_q != StFinish);
    end

endmodule

// File: tb/tb_spike_network_arbiter.sv
// Randomized self-checking bench for spike_network_arbiter with an 8-neuron bank.
module tb_spike_network_arbiter;

    logic        clk;
    logic        reset_l;
    logic        start;
    logic [8:0]  active_neuron;
    logic [15:0] max_iter;
    logic [7:0]  en_network;
    logic [15:0] spike_out;
    logic [10:0] spike_in;
    logic        network_done;
    logic [15:0] iter_count;
    logic        busy;
    logic        anneal_done;
    logic        illegal_spike;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference-model state: round-robin start point and sticky illegal flag.
    int rr_m  = 0;
    bit ill_m = 0;

    spike_network_arbiter #(
        .NUM_NEURON     (8),
        .NEURON_ID_WIDTH(9),
        .TEN_DATA_WIDTH (2),
        .ITER_WIDTH     (16)
    ) dut (
        .clk          (clk),
        .reset_l      (reset_l),
        .start        (start),
        .active_neuron(active_neuron),
        .max_iter     (max_iter),
        .en_network   (en_network),
        .spike_out    (spike_out),
        .spike_in     (spike_in),
        .networkDone  (network_done),
        .iter_count   (iter_count),
        .busy         (busy),
        .anneal_done  (anneal_done),
        .illegal_spike(illegal_spike)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int n_eff_of(input logic [8:0] an);
        return (an > 9'd8) ? 8 : int'(an);
    endfunction

    function automatic logic [15:0] rand_spikes();
        logic [15:0] v;
        int r;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(0, 7);
            if (r < 3)      v[2*i +: 2] = 2'd0;
            else if (r < 5) v[2*i +: 2] = 2'd1;
            else if (r < 7) v[2*i +: 2] = 2'd2;
            else            v[2*i +: 2] = 2'd3;
        end
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_l = 1'b0;
        start   = 1'b0;
        @(negedge clk);
        reset_l = 1'b1;
        rr_m    = 0;
        ill_m   = 0;
    endtask

    task automatic check_idle_zero(input string name);
        n_cmp++;
        if ({spike_in, network_done, iter_count, busy, anneal_done, illegal_spike} !== '0) begin
            n_bad++;
            $display("FAIL %s: outputs spike_in=%0h nd=%0b iter=%0d busy=%0b done=%0b ill=%0b, required all 0",
                     name, spike_in, network_done, iter_count, busy, anneal_done, illegal_spike);
        end
    endtask

    // Runs one start..FINISH..IDLE cycle with max_iter=mi, checking each iteration against the model.
    task automatic run_check(input int mi, input bit rand_spk, input string name);
        int n, c, k, idx;
        bit seen;
        logic [1:0]  code;
        logic [10:0] exp_spk;
        n = n_eff_of(active_neuron);
        max_iter = 16'(mi);
        start = 1'b1;
        for (int it = 0; it < mi; it++) begin
            // Model: first spiking neuron at or after rr_m, scanning modulo n.
            k = n;
            exp_spk = '0;
            for (int j = 0; j < n; j++) begin
                idx  = (rr_m + j) % n;
                code = spike_out[2*idx +: 2];
                if (code == 2'd3) ill_m = 1;
                if (code == 2'd1 || code == 2'd2) begin
                    k = j + 1;
                    exp_spk = {code, 9'(idx)};
                    rr_m = (idx + 1) % n;
                    break;
                end
            end
            c = 0;
            seen = 0;
            while (c < 200 && !seen) begin
                @(negedge clk);
                c++;
                if (network_done) seen = 1;
            end
            n_cmp++;
            if (!seen) begin
                n_bad++;
                $display("FAIL %s timeout: no networkDone in iter %0d within %0d cycles", name, it, c);
                start = 1'b0;
                return;
            end
            n_cmp++;
            if (c !== k + 2) begin
                n_bad++;
                $display("FAIL %s latency iter %0d: got %0d cycles, required %0d", name, it, c, k + 2);
            end
            n_cmp++;
            if (spike_in !== exp_spk) begin
                n_bad++;
                $display("FAIL %s spike_in iter %0d: got %0h, required %0h", name, it, spike_in, exp_spk);
            end
            n_cmp++;
            if (iter_count !== 16'(it) || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s iter/busy at release %0d: got iter=%0d busy=%0b, required iter=%0d busy=1",
                         name, it, iter_count, busy, it);
            end
            n_cmp++;
            if (illegal_spike !== ill_m) begin
                n_bad++;
                $display("FAIL %s illegal_spike iter %0d: got %0b, required %0b", name, it, illegal_spike, ill_m);
            end
            if (rand_spk) spike_out = rand_spikes();
        end
        @(negedge clk);
        n_cmp++;
        if (anneal_done !== 1'b1 || busy !== 1'b0 || network_done !== 1'b0 || iter_count !== 16'(mi)) begin
            n_bad++;
            $display("FAIL %s finish: got done=%0b busy=%0b nd=%0b iter=%0d, required done=1 busy=0 nd=0 iter=%0d",
                     name, anneal_done, busy, network_done, iter_count, mi);
        end
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (anneal_done !== 1'b0 || busy !== 1'b0 || iter_count !== 16'(mi)) begin
            n_bad++;
            $display("FAIL %s back to idle: got done=%0b busy=%0b iter=%0d, required 0 0 %0d",
                     name, anneal_done, busy, iter_count, mi);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        check_idle_zero("reset");
    endtask

    task automatic test_single_firer();
        active_neuron = 9'd8;
        en_network    = 8'hFF;
        spike_out     = 16'h0800;           // neuron 5 = 2
        run_check(1, 0, "single_firer");
        n_cmp++;
        if (spike_in !== 11'h405) begin
            n_bad++;
            $display("FAIL single_firer held spike_in: got %0h, required 405", spike_in);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        active_neuron = 9'd8;
        en_network    = 8'hFF;
        spike_out     = 16'h1010;           // neurons 2 and 6 = 1
        run_check(3, 0, "round_robin");
        // Every neuron firing exposes the round-robin pointer directly (expected 3).
        spike_out = 16'h5555;
        run_check(1, 0, "rr_pointer");
        n_cmp++;
        if (spike_in !== {2'b01, 9'd3}) begin
            n_bad++;
            $display("FAIL rr_pointer winner: got %0h, required %0h", spike_in, {2'b01, 9'd3});
        end
    endtask

    task automatic test_no_firer();
        active_neuron = 9'd8;
        en_network    = 8'hFF;
        spike_out     = 16'h0000;
        run_check(2, 0, "no_firer");
    endtask

    task automatic test_masking();
        do_reset();
        active_neuron = 9'd4;
        en_network    = 8'h0F;
        spike_out     = 16'h1000;           // neuron 6 = 1, outside n_eff
        run_check(1, 0, "masking");
    endtask

    task automatic test_wait_gate();
        int c;
        do_reset();
        active_neuron = 9'd8;
        en_network    = 8'hFB;              // neuron 2 not yet parked
        spike_out     = 16'h0080;           // neuron 3 = 2
        max_iter      = 16'd1;
        start         = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (network_done !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL wait_gate hold cycle %0d: got nd=%0b busy=%0b, required 0 1", i, network_done, busy);
            end
        end
        en_network = 8'hFF;
        c = 0;
        while (c < 100 && network_done !== 1'b1) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (c !== 5 || spike_in !== 11'h403) begin
            n_bad++;
            $display("FAIL wait_gate release: got %0d cycles spike_in=%0h, required 5 cycles 403", c, spike_in);
        end
        rr_m = 4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_max_iter_zero();
        do_reset();
        active_neuron = 9'd8;
        en_network    = 8'hFF;
        spike_out     = 16'h5555;
        max_iter      = 16'd0;
        start         = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (anneal_done !== 1'b1 || network_done !== 1'b0 || busy !== 1'b0 || iter_count !== 16'd0) begin
                n_bad++;
                $display("FAIL max_iter_zero cycle %0d: got done=%0b nd=%0b busy=%0b iter=%0d, required 1 0 0 0",
                         i, anneal_done, network_done, busy, iter_count);
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        do_reset();
        active_neuron = 9'd8;
        en_network    = 8'hFF;
        spike_out     = 16'h010C;           // neuron 1 = 3, neuron 4 = 1
        run_check(1, 0, "illegal");
        spike_out     = 16'h0100;           // illegal code gone; flag must stay set
        run_check(1, 0, "illegal_sticky");
    endtask

    task automatic test_reset_mid_scan();
        active_neuron = 9'd8;
        en_network    = 8'hFF;
        spike_out     = 16'h0000;
        max_iter      = 16'd2;
        start         = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_scan busy before reset: got %0b, required 1", busy);
        end
        reset_l = 1'b0;
        start   = 1'b0;
        @(negedge clk);
        reset_l = 1'b1;
        rr_m    = 0;
        ill_m   = 0;
        check_idle_zero("mid_scan_reset");
        spike_out = 16'h5555;
        run_check(1, 0, "restart");
        n_cmp++;
        if (spike_in !== 11'h200) begin
            n_bad++;
            $display("FAIL restart winner: got %0h, required 200", spike_in);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            do_reset();
            active_neuron = 9'($urandom_range(0, 12));
            en_network    = 8'($urandom);
            for (int i = 0; i < n_eff_of(active_neuron); i++) en_network[i] = 1'b1;
            spike_out     = rand_spikes();
            run_check($urandom_range(1, 6), 1, "random");
        end
    endtask

    initial begin
        reset_l       = 1'b0;
        start         = 1'b0;
        active_neuron = 9'd8;
        max_iter      = 16'd0;
        en_network    = 8'h00;
        spike_out     = 16'h0000;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_firer();
        test_round_robin();
        test_no_firer();
        test_masking();
        test_wait_gate();
        test_max_iter_zero();
        test_illegal();
        test_reset_mid_scan();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
